// File: rtl/spm_arb_pkg.sv
// spm_arb_pkg -- shared definitions for the scratch-pad memory arbiter.
//   SPM geometry (word width, depth, address width), FSM state encodings
//   and master indices used by spm_arb and spm_arb_rr.
// Optional feature macro used by the slice: SPM_ARB_LOCK_EN (see spm_arb.sv).
package spm_arb_pkg;

  localparam int WORD_W     = 32;
  localparam int SPM_DEPTH  = 4096;
  localparam int SPM_ADDR_W = $clog2(SPM_DEPTH);

  typedef enum logic [1:0] {
    SPM_ARB_ST_IDLE   = 2'd0,
    SPM_ARB_ST_ACCESS = 2'd1,
    SPM_ARB_ST_RESP   = 2'd2
  } spm_arb_st_e;

  localparam logic SPM_ARB_M0 = 1'b0;
  localparam logic SPM_ARB_M1 = 1'b1;

endpackage

// File: rtl/spm_arb_rr.sv
// spm_arb_rr -- combinational 2-way round-robin pick.
//   req    : request vector, bit N = master N
//   prio   : index of the master holding priority
//   lock   : current owner holds a lock (only meaningful at RESP exit)
//   owner  : index of the current owner
//   winner : selected master index
//   valid  : at least one request present
//   hold   : winner was chosen because of the lock (priority must not rotate)
import spm_arb_pkg::*;

module spm_arb_rr (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       lock,
  input  logic       owner,
  output logic       winner,
  output logic       valid,
  output logic       hold
);

  always_comb begin
    valid  = |req;
    hold   = 1'b0;
    winner = prio;
    if (lock && req[owner]) begin
      winner = owner;
      hold   = 1'b1;
    end else if (req[prio]) begin
      winner = prio;
    end else begin
      // lone requester wins regardless of priority
      winner = ~prio;
    end
  end

endmodule

// File: rtl/spm_arb.sv
// spm_arb -- two-master arbiter in front of a single-port scratch-pad memory.
//   clk, reset          : clock, asynchronous active-high reset
//   mN_req/we/addr/wr_data : master N request and transaction fields (N=0,1)
//   mN_lock             : ownership lock (only when SPM_ARB_LOCK_EN is defined)
//   mN_gnt              : master N owns the SPM port (ACCESS through RESP)
//   mN_ack, mN_rd_data  : one-cycle completion pulse and read data
//   ram_en/we/addr/wr_data, ram_rd_data : SPM port (registered read, 1 cycle)
// Config macro: SPM_ARB_LOCK_EN enables the mN_lock ports and lock hold.
//
// state  | meaning
// IDLE   | no transaction, arbitrate incoming requests
// ACCESS | SPM port driven from latched copies, one cycle
// RESP   | owner acked, read data returned; re-arbitrate at exit
import spm_arb_pkg::*;

module spm_arb #(
  parameter int INIT_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [SPM_ADDR_W-1:0] m0_addr,
  input  logic [WORD_W-1:0]     m0_wr_data,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [SPM_ADDR_W-1:0] m1_addr,
  input  logic [WORD_W-1:0]     m1_wr_data,
`ifdef SPM_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic                  m0_gnt,
  output logic                  m0_ack,
  output logic [WORD_W-1:0]     m0_rd_data,
  output logic                  m1_gnt,
  output logic                  m1_ack,
  output logic [WORD_W-1:0]     m1_rd_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [SPM_ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0]     ram_wr_data,
  input  logic [WORD_W-1:0]     ram_rd_data
);

  localparam logic INIT_P = (INIT_PRIO != 0);

  spm_arb_st_e           state_q, state_d;
  logic                  owner_q, we_q, prio_q;
  logic [SPM_ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0]     wdata_q;

  logic [1:0] req;
  logic       lock_act, win, win_valid, win_hold, load;

  assign req = {m1_req, m0_req};

`ifdef SPM_ARB_LOCK_EN
  // lock is only honoured at the end of the owner's own transaction
  assign lock_act = (state_q == SPM_ARB_ST_RESP) && (owner_q ? m1_lock : m0_lock);
`else
  assign lock_act = 1'b0;
`endif

  spm_arb_rr u_rr (
    .req    (req),
    .prio   (prio_q),
    .lock   (lock_act),
    .owner  (owner_q),
    .winner (win),
    .valid  (win_valid),
    .hold   (win_hold)
  );

  // a new owner can be taken from IDLE or at RESP exit, never out of ACCESS
  assign load = win_valid && (state_q != SPM_ARB_ST_ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SPM_ARB_ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPM_ARB_ST_IDLE:   state_d = win_valid ? SPM_ARB_ST_ACCESS : SPM_ARB_ST_IDLE;
      SPM_ARB_ST_ACCESS: state_d = SPM_ARB_ST_RESP;
      SPM_ARB_ST_RESP:   state_d = win_valid ? SPM_ARB_ST_ACCESS : SPM_ARB_ST_IDLE;
      default:           state_d = SPM_ARB_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      prio_q  <= INIT_P;
    end else if (load) begin
      owner_q <= win;
      we_q    <= win ? m1_we      : m0_we;
      addr_q  <= win ? m1_addr    : m0_addr;
      wdata_q <= win ? m1_wr_data : m0_wr_data;
      if (!win_hold) prio_q <= ~win;
    end
  end

  always_comb begin
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_rd_data  = '0;
    m1_rd_data  = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_wr_data = wdata_q;
    case (state_q)
      SPM_ARB_ST_ACCESS: begin
        m0_gnt = (owner_q == SPM_ARB_M0);
        m1_gnt = (owner_q == SPM_ARB_M1);
        ram_en = 1'b1;
        ram_we = we_q;
      end
      SPM_ARB_ST_RESP: begin
        m0_gnt = (owner_q == SPM_ARB_M0);
        m1_gnt = (owner_q == SPM_ARB_M1);
        m0_ack = m0_gnt;
        m1_ack = m1_gnt;
        // writes return zero; the SPM output is stale during a write ack
        if (m0_gnt && !we_q) m0_rd_data = ram_rd_data;
        if (m1_gnt && !we_q) m1_rd_data = ram_rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spm_arb.sv
module tb_spm_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [11:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wr_data = 0, m1_wr_data = 0;
`ifdef SPM_ARB_LOCK_EN
  logic        m0_lock = 0, m1_lock = 0;
`endif
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack, ram_en, ram_we;
  logic [31:0] m0_rd_data, m1_rd_data, ram_wr_data;
  logic [31:0] ram_rd_data = 0;
  logic [11:0] ram_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spm_arb #(.INIT_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
`ifdef SPM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  // SPM model: registered read, write-through to the array
  logic [31:0] mem [0:4095];
  bit          mem_init = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
      mem_init = 1;
    end
    if (ram_en) begin
      ram_rd_data <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_wr_data;
    end
  end

  // protocol monitor
  logic pa0 = 0, pa1 = 0;
  always @(negedge clk) begin
    checks++;
    if ((m0_gnt && m1_gnt) || (ram_en && !(m0_gnt ^ m1_gnt)) ||
        (ram_en && (m0_ack || m1_ack)) || (m0_ack && pa0) || (m1_ack && pa1) ||
        (m0_ack && !m0_gnt) || (m1_ack && !m1_gnt)) begin
      errors++;
      $display("FAIL monitor t=%0t actual gnt=%b%b ack=%b%b en=%b prev_ack=%b%b required legal",
               $time, m1_gnt, m0_gnt, m1_ack, m0_ack, ram_en, pa1, pa0);
    end
    pa0 = m0_ack;
    pa1 = m1_ack;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic ack_of(input bit m);
    return m ? m1_ack : m0_ack;
  endfunction
  function automatic logic gnt_of(input bit m);
    return m ? m1_gnt : m0_gnt;
  endfunction
  function automatic logic [31:0] rd_of(input bit m);
    return m ? m1_rd_data : m0_rd_data;
  endfunction

  task automatic set_req(input bit m, input bit r, input bit we, input logic [11:0] a, input logic [31:0] d);
    if (m) begin m1_req = r; m1_we = we; m1_addr = a; m1_wr_data = d; end
    else   begin m0_req = r; m0_we = we; m0_addr = a; m0_wr_data = d; end
  endtask

  // single transaction from IDLE; called at posedge+1
  task automatic do_txn(input bit m, input bit we, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string nm);
    int  n;
    bit  got;
    set_req(m, 1'b1, we, a, d);
    @(posedge clk); #1;
    chk({nm, "_access_en"}, {31'b0, ram_en}, 1);
    chk({nm, "_access_gnt"}, {31'b0, gnt_of(m)}, 1);
    chk({nm, "_access_ack"}, {31'b0, ack_of(m)}, 0);
    chk({nm, "_ram_addr"}, {20'b0, ram_addr}, {20'b0, a});
    chk({nm, "_ram_we"}, {31'b0, ram_we}, {31'b0, we});
    if (we) chk({nm, "_ram_wdata"}, ram_wr_data, d);
    n = 1; got = 0;
    while (!got && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (ack_of(m)) got = 1;
    end
    chk({nm, "_latency"}, n, 2);
    if (got) chk({nm, "_rdata"}, rd_of(m), exp);
    chk({nm, "_resp_en"}, {31'b0, ram_en}, 0);
    set_req(m, 1'b0, 1'b0, 12'h0, 32'h0);
    @(posedge clk); #1;
    chk({nm, "_idle_gnt"}, {30'b0, m1_gnt, m0_gnt}, 0);
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  int   who [4];
  int   at  [4];
  logic [31:0] dat [4];

  initial begin
    vecs[0] = '{m:0, we:1, addr:12'h010, wd:32'hDEADBEEF, exp:32'h0};
    vecs[1] = '{m:0, we:0, addr:12'h010, wd:32'h0,        exp:32'hDEADBEEF};
    vecs[2] = '{m:1, we:1, addr:12'h020, wd:32'h12345678, exp:32'h0};
    vecs[3] = '{m:1, we:0, addr:12'h020, wd:32'h0,        exp:32'h12345678};
    vecs[4] = '{m:0, we:0, addr:12'h003, wd:32'h0,        exp:32'h4};
    vecs[5] = '{m:1, we:1, addr:12'hFFF, wd:32'hA5A5A5A5, exp:32'h0};
    vecs[6] = '{m:0, we:0, addr:12'hFFF, wd:32'h0,        exp:32'hA5A5A5A5};
    vecs[7] = '{m:1, we:0, addr:12'h000, wd:32'h0,        exp:32'h1};

    // reset state, before any clock edge
    #2;
    chk("rst_ctrl", {26'b0, m0_gnt, m1_gnt, m0_ack, m1_ack, ram_en, ram_we}, 0);
    chk("rst_addr", {20'b0, ram_addr}, 0);
    chk("rst_wdata", ram_wr_data, 0);
    chk("rst_rd", m0_rd_data | m1_rd_data, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp, $sformatf("vec%0d", i));

    // reset during ACCESS of an m1 write aborts it
    begin
      int acks;
      set_req(1, 1, 1, 12'h030, 32'hCAFEF00D);
      @(posedge clk); #1;
      chk("abort_access_en", {31'b0, ram_en}, 1);
      chk("abort_access_gnt", {31'b0, m1_gnt}, 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_ctrl", {26'b0, m0_gnt, m1_gnt, m0_ack, m1_ack, ram_en, ram_we}, 0);
      chk("abort_addr", {20'b0, ram_addr}, 0);
      chk("abort_wdata", ram_wr_data, 0);
      set_req(1, 0, 0, 12'h0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      acks = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (m1_ack) acks++;
      end
      chk("abort_no_ack", acks, 0);
      do_txn(0, 0, 12'h010, 32'h0, 32'hDEADBEEF, "post_rst_rd");
    end

    // simultaneous held requests after reset alternate m0,m1,m0,m1
    begin
      int k;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      set_req(0, 1, 0, 12'h010, 32'h0);
      set_req(1, 1, 0, 12'h001, 32'h0);
      k = 0;
      for (int c = 1; c <= 20 && k < 4; c++) begin
        @(posedge clk); #1;
        if (m0_ack || m1_ack) begin
          who[k] = m1_ack ? 1 : 0;
          at[k]  = c;
          dat[k] = m1_ack ? m1_rd_data : m0_rd_data;
          k++;
          if (k == 4) begin
            set_req(0, 0, 0, 12'h0, 32'h0);
            set_req(1, 0, 0, 12'h0, 32'h0);
          end
        end
      end
      chk("rr_count", k, 4);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("rr_who%0d", j), who[j], j % 2);
        chk($sformatf("rr_at%0d", j), at[j], 2 * (j + 1));
        chk($sformatf("rr_data%0d", j), dat[j], (j % 2) ? 32'h2 : 32'hDEADBEEF);
      end
      set_req(0, 0, 0, 12'h0, 32'h0);
      set_req(1, 0, 0, 12'h0, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end

    // m1 alone, four back-to-back reads of 0x000..0x003
    begin
      int last, k;
      set_req(1, 1, 0, 12'h000, 32'h0);
      last = 0; k = 0;
      for (int c = 1; c <= 20 && k < 4; c++) begin
        @(posedge clk); #1;
        if (m1_ack) begin
          chk($sformatf("b2b_gap%0d", k), c - last, 2);
          chk($sformatf("b2b_data%0d", k), m1_rd_data, 32'(k + 1));
          last = c;
          k++;
          if (k < 4) set_req(1, 1, 0, 12'(k), 32'h0);
          else       set_req(1, 0, 0, 12'h0, 32'h0);
        end
      end
      chk("b2b_count", k, 4);
      set_req(1, 0, 0, 12'h0, 32'h0);
      @(posedge clk); #1;
    end

`ifdef SPM_ARB_LOCK_EN
    // m0 locked for three transactions, m1 waits for the fourth slot
    begin
      int k, n0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m0_lock = 1'b1;
      set_req(0, 1, 0, 12'h003, 32'h0);
      set_req(1, 1, 0, 12'h002, 32'h0);
      k = 0; n0 = 0;
      for (int c = 1; c <= 20 && k < 4; c++) begin
        @(posedge clk); #1;
        if (m0_ack || m1_ack) begin
          who[k] = m1_ack ? 1 : 0;
          at[k]  = c;
          dat[k] = m1_ack ? m1_rd_data : m0_rd_data;
          k++;
          if (m0_ack) begin
            n0++;
            if (n0 == 3) begin m0_lock = 1'b0; set_req(0, 0, 0, 12'h0, 32'h0); end
          end
          if (m1_ack) set_req(1, 0, 0, 12'h0, 32'h0);
        end
      end
      chk("lock_count", k, 4);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("lock_who%0d", j), who[j], (j == 3) ? 1 : 0);
        chk($sformatf("lock_at%0d", j), at[j], 2 * (j + 1));
        chk($sformatf("lock_data%0d", j), dat[j], (j == 3) ? 32'h3 : 32'h4);
      end
      m0_lock = 1'b0;
      set_req(0, 0, 0, 12'h0, 32'h0);
      set_req(1, 0, 0, 12'h0, 32'h0);
      @(posedge clk); #1;
    end
`endif

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
